// File: rtl/rp_seg_collect_if.sv
// Segment-in / vector-out bundle for rp_seg_collect.
// master drives segments and the output-side ready; slave is the collector.
interface rp_seg_collect_if #(
    parameter int DIM_W           = 26,
    parameter int DIMS_PER_CC     = 1024,
    parameter int SEQ_CYCLE_COUNT = 4
);
    localparam int SEG_W = DIM_W * DIMS_PER_CC;
    localparam int HV_W  = SEG_W * SEQ_CYCLE_COUNT;

    logic             flush;
    logic             seg_valid;
    logic             seg_ready;
    logic [SEG_W-1:0] seg_data;
    logic [1:0]       seg_idx;
    logic             out_valid;
    logic             out_ready;
    logic [HV_W-1:0]  full_hv;
    logic [15:0]      vec_count;

    modport master (
        output flush, seg_valid, seg_data, out_ready,
        input  seg_ready, seg_idx, out_valid, full_hv, vec_count
    );

    modport slave (
        input  flush, seg_valid, seg_data, out_ready,
        output seg_ready, seg_idx, out_valid, full_hv, vec_count
    );
endinterface

// File: rtl/rp_seg_collect.sv
// Collects four class-HV segments into one full vector and hands it
// downstream with a valid/ready handshake.
module rp_seg_collect #(
    parameter int DIM_W           = 26,
    parameter int DIMS_PER_CC     = 1024,
    parameter int SEQ_CYCLE_COUNT = 4
) (
    input logic           clk,
    input logic           nrst,
    rp_seg_collect_if.slave bus
);
    localparam int SEG_W = DIM_W * DIMS_PER_CC;
    localparam int HV_W  = SEG_W * SEQ_CYCLE_COUNT;

    if (SEQ_CYCLE_COUNT != 4) begin : g_bad_cfg
        $error("rp_seg_collect supports only SEQ_CYCLE_COUNT == 4");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t          state_q;
    logic [1:0]      idx_q;
    logic            out_valid_q;
    logic [15:0]     vec_count_q;
    logic [HV_W-1:0] hv_q;

    logic seg_ready;
    logic seg_fire;
    logic out_fire;

    // In FULL a new segment can only land in slot 0 as the vector leaves.
    assign seg_ready = (state_q == COLLECT) || bus.out_ready;
    assign seg_fire  = bus.seg_valid && seg_ready;
    assign out_fire  = (state_q == FULL) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= COLLECT;
            idx_q       <= 2'd0;
            out_valid_q <= 1'b0;
            vec_count_q <= 16'd0;
            hv_q        <= '0;
        end else if (bus.flush) begin
            state_q     <= COLLECT;
            idx_q       <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (seg_fire) begin
                for (int k = 0; k < 4; k++) begin
                    if (idx_q == 2'(k)) begin
                        hv_q[k*SEG_W +: SEG_W] <= bus.seg_data;
                    end
                end
                idx_q <= idx_q + 2'd1;
            end
            case (state_q)
                COLLECT: begin
                    if (seg_fire && idx_q == 2'd3) begin
                        state_q     <= FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_q     <= COLLECT;
                        out_valid_q <= 1'b0;
                        vec_count_q <= vec_count_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.seg_ready = seg_ready;
    assign bus.seg_idx   = idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.full_hv   = hv_q;
    assign bus.vec_count = vec_count_q;
endmodule
